// File: rtl/tluh_atomic_responder.sv
// -----------------------------------------------------------------------------
// tluh_pkg / tluh_atomic_responder
//
// Purpose: TileLink-UH slave that serves Get, PutFull, PutPartial, ArithmeticData
// and (optionally) LogicalData requests against a simple req/gnt/rvalid word
// memory. It handles one request at a time. Atomics are read-modify-write:
// the old word is returned on D and the computed result is written back.
//
// Configuration macro: TLUH_LOGICAL_EN
//   defined   -> LogicalData (XOR/OR/AND/SWAP) is executed.
//   undefined -> LogicalData is answered with a denied (d_error_o) response.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   a_valid_i / a_ready_o         A-channel handshake
//   a_opcode_i, a_param_i         request opcode and atomic sub-operation
//   a_address_i, a_data_i,
//   a_mask_i, a_source_i          request fields (latched on acceptance)
//   d_valid_o / d_ready_i         D-channel handshake
//   d_opcode_o, d_data_o,
//   d_source_o, d_error_o         response fields
//   mem_req_o / mem_gnt_i         memory request / grant
//   mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_be_o         write enable, word address, data, byte enables
//   mem_rvalid_i, mem_rdata_i     read data return
// -----------------------------------------------------------------------------
package tluh_pkg;
    parameter int TL_DW = 32;

    // A-channel opcodes
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGIC       = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;

    // ArithmeticData params
    localparam logic [2:0] AR_MIN  = 3'd0;
    localparam logic [2:0] AR_MAX  = 3'd1;
    localparam logic [2:0] AR_MINU = 3'd2;
    localparam logic [2:0] AR_MAXU = 3'd3;
    localparam logic [2:0] AR_ADD  = 3'd4;

`ifdef TLUH_LOGICAL_EN
    // LogicalData params
    localparam logic [2:0] LG_XOR  = 3'd0;
    localparam logic [2:0] LG_OR   = 3'd1;
    localparam logic [2:0] LG_AND  = 3'd2;
    localparam logic [2:0] LG_SWAP = 3'd3;
`endif

    // D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
endpackage

module tluh_atomic_responder
    import tluh_pkg::*;
#(
    parameter int DW = TL_DW,
    parameter int AW = 32,
    parameter int SW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            a_valid_i,
    output logic            a_ready_o,
    input  logic [2:0]      a_opcode_i,
    input  logic [2:0]      a_param_i,
    input  logic [AW-1:0]   a_address_i,
    input  logic [DW-1:0]   a_data_i,
    input  logic [DW/8-1:0] a_mask_i,
    input  logic [SW-1:0]   a_source_i,
    output logic            d_valid_o,
    input  logic            d_ready_i,
    output logic [2:0]      d_opcode_o,
    output logic [DW-1:0]   d_data_o,
    output logic [SW-1:0]   d_source_o,
    output logic            d_error_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i
);
    localparam int BW = DW / 8;

    typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_RESP} state_e;

    state_e          state_q, state_d;
    logic [2:0]      opcode_q, opcode_d;
    logic [2:0]      param_q, param_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [BW-1:0]   mask_q, mask_d;
    logic [SW-1:0]   source_q, source_d;
    logic [DW-1:0]   old_q, old_d;
    logic            err_q, err_d;

    logic            is_put;
    logic [AW-1:0]   word_addr;
    logic [BW-1:0]   be;
    logic [DW-1:0]   result;

    // Which opcode/param pairs this build can execute; everything else is denied.
    function automatic logic is_legal(input logic [2:0] op, input logic [2:0] prm);
        case (op)
            OP_PUT_FULL, OP_PUT_PARTIAL, OP_GET: is_legal = 1'b1;
            OP_ARITH:                            is_legal = (prm <= AR_ADD);
`ifdef TLUH_LOGICAL_EN
            OP_LOGIC:                            is_legal = (prm <= LG_SWAP);
`endif
            default:                             is_legal = 1'b0;
        endcase
    endfunction

    assign is_put    = (opcode_q == OP_PUT_FULL) || (opcode_q == OP_PUT_PARTIAL);
    assign word_addr = addr_q & ~AW'(BW - 1);
    assign be        = (opcode_q == OP_PUT_PARTIAL) ? mask_q : '1;

    // Write-back value. Puts and SWAP simply write the latched A data.
    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        result = data_q;
        if (opcode_q == OP_ARITH) begin
            case (param_q)
                AR_MIN:  result = ($signed(old_q) < $signed(data_q)) ? old_q : data_q;
                AR_MAX:  result = ($signed(old_q) > $signed(data_q)) ? old_q : data_q;
                AR_MINU: result = (old_q < data_q) ? old_q : data_q;
                AR_MAXU: result = (old_q > data_q) ? old_q : data_q;
                AR_ADD:  result = old_q + data_q;   // carry out is dropped
                default: result = data_q;
            endcase
        end
`ifdef TLUH_LOGICAL_EN
        if (opcode_q == OP_LOGIC) begin
            case (param_q)
                LG_XOR:  result = old_q ^ data_q;
                LG_OR:   result = old_q | data_q;
                LG_AND:  result = old_q & data_q;
                default: result = data_q;           // SWAP
            endcase
        end
`endif
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        param_d     = param_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        source_d    = source_q;
        old_d       = old_q;
        err_d       = err_q;

        a_ready_o   = 1'b0;
        d_valid_o   = 1'b0;
        d_opcode_o  = D_ACCESS_ACK;
        d_data_o    = '0;
        d_source_o  = '0;
        d_error_o   = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;

        case (state_q)
            S_IDLE: begin
                a_ready_o = 1'b1;
                if (a_valid_i) begin
                    opcode_d = a_opcode_i;
                    param_d  = a_param_i;
                    addr_d   = a_address_i;
                    data_d   = a_data_i;
                    mask_d   = a_mask_i;
                    source_d = a_source_i;
                    old_d    = '0;
                    err_d    = !is_legal(a_opcode_i, a_param_i);
                    if (!is_legal(a_opcode_i, a_param_i))
                        state_d = S_RESP;
                    else if (a_opcode_i == OP_PUT_FULL || a_opcode_i == OP_PUT_PARTIAL)
                        state_d = S_WR_REQ;
                    else
                        state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = word_addr;
                mem_be_o   = be;
                if (mem_gnt_i) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_rvalid_i) begin
                    old_d   = mem_rdata_i;
                    state_d = (opcode_q == OP_GET) ? S_RESP : S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = word_addr;
                mem_wdata_o = result;
                mem_be_o    = be;
                if (mem_gnt_i) state_d = S_RESP;
            end
            S_RESP: begin
                d_valid_o  = 1'b1;
                d_opcode_o = (is_put && !err_q) ? D_ACCESS_ACK : D_ACCESS_ACK_DATA;
                d_data_o   = (is_put || err_q) ? '0 : old_q;
                d_source_o = source_q;
                d_error_o  = err_q;
                if (d_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: request/data registers are reset too, so every derived output is zero
    // while rst_i is held and a reset mid-transaction leaves nothing stale behind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            param_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            source_q <= '0;
            old_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            opcode_q <= opcode_d;
            param_q  <= param_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            source_q <= source_d;
            old_q    <= old_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_tluh_atomic_responder.sv
// -----------------------------------------------------------------------------
// Testbench for tluh_atomic_responder: a table of directed request vectors with
// hand-computed responses and memory contents, run against a small behavioural
// word memory with configurable grant and read latency, plus hand-written
// sequences for D backpressure and reset during an outstanding read.
// -----------------------------------------------------------------------------
module tb_tluh_atomic_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic        a_ready_o;
    logic [2:0]  a_opcode, a_param;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    logic [7:0]  a_source;
    logic        d_valid_o, d_ready;
    logic [2:0]  d_opcode_o;
    logic [31:0] d_data_o;
    logic [7:0]  d_source_o;
    logic        d_error_o;
    logic        mem_req_o, mem_we_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'hBAD0_BAD0;

    always #5 clk = ~clk;

    tluh_atomic_responder #(.DW(32), .AW(32), .SW(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready_o),
        .a_opcode_i(a_opcode), .a_param_i(a_param),
        .a_address_i(a_address), .a_data_i(a_data),
        .a_mask_i(a_mask), .a_source_i(a_source),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready),
        .d_opcode_o(d_opcode_o), .d_data_o(d_data_o),
        .d_source_o(d_source_o), .d_error_o(d_error_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    // ---------------- comparison bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural word memory ----------------
    logic [31:0] mem [0:63];
    int          gnt_lat = 0, rd_lat = 1;
    int          gwait = 0, rd_cnt = 0;
    int          req_cycles = 0, misaligned = 0, wdata_moved = 0;
    logic        req_seen = 1'b0, we_seen = 1'b0;
    logic [31:0] addr_seen = '0, wdata_seen = '0, rd_addr = '0;
    logic [3:0]  be_seen = '0;

    // Runs on the falling edge: commits the handshake of the previous rising
    // edge, then sets up gnt/rvalid for the next rising edge.
    always @(negedge clk) begin
        if (mem_gnt_i && req_seen) begin
            if (we_seen) begin
                for (int b = 0; b < 4; b++)
                    if (be_seen[b]) mem[addr_seen[7:2]][8*b +: 8] = wdata_seen[8*b +: 8];
            end else begin
                rd_cnt  = rd_lat;
                rd_addr = addr_seen;
            end
            gwait = 0;
        end
        if (req_seen && we_seen && !mem_gnt_i && mem_req_o && mem_we_o && mem_wdata_o !== wdata_seen)
            wdata_moved++;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hBAD0_BAD0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem[rd_addr[7:2]];
            end
        end
        req_seen   = mem_req_o;
        we_seen    = mem_we_o;
        addr_seen  = mem_addr_o;
        wdata_seen = mem_wdata_o;
        be_seen    = mem_be_o;
        if (mem_req_o) begin
            req_cycles++;
            if (mem_addr_o[1:0] != 2'b00) misaligned++;
            if (gwait >= gnt_lat) mem_gnt_i = 1'b1;
            else begin
                gwait++;
                mem_gnt_i = 1'b0;
            end
        end else begin
            mem_gnt_i = 1'b0;
            gwait     = 0;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  op;
        logic [2:0]  prm;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [7:0]  src;
        logic [31:0] init;
        int          gl;
        int          rl;
        logic [2:0]  e_op;
        logic [31:0] e_data;
        logic        e_err;
        logic [31:0] e_mem;
        int          e_lat;   // 0 = latency not checked
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] prm, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] mask, input logic [7:0] src,
                                input logic [31:0] init, input int gl, input int rl,
                                input logic [2:0] e_op, input logic [31:0] e_data, input logic e_err,
                                input logic [31:0] e_mem, input int e_lat);
        vec_t v;
        v.op = op; v.prm = prm; v.addr = addr; v.data = data; v.mask = mask; v.src = src;
        v.init = init; v.gl = gl; v.rl = rl; v.e_op = e_op; v.e_data = e_data;
        v.e_err = e_err; v.e_mem = e_mem; v.e_lat = e_lat;
        return v;
    endfunction

    // ---------------- one transaction ----------------
    task automatic txn(input vec_t v, input int hold,
                       output logic [2:0] dop, output logic [31:0] ddata, output logic derr,
                       output logic [7:0] dsrc, output int lat, output logic got);
        int guard;
        got = 1'b0; lat = 0; dop = '0; ddata = '0; derr = 1'b0; dsrc = '0;
        gnt_lat = v.gl;
        rd_lat  = v.rl;
        @(negedge clk);
        req_cycles = 0; misaligned = 0; wdata_moved = 0;
        a_valid = 1'b1; a_opcode = v.op; a_param = v.prm; a_address = v.addr;
        a_data = v.data; a_mask = v.mask; a_source = v.src;
        guard = 0;
        while (!a_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!a_ready_o) begin
            a_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        lat = 1;
        while (!d_valid_o && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!d_valid_o) return;
        got = 1'b1;
        dop = d_opcode_o; ddata = d_data_o; derr = d_error_o; dsrc = d_source_o;
        for (int i = 0; i < hold; i++) begin
            check($sformatf("hold%0d d_valid", i), d_valid_o, 1'b1);
            check($sformatf("hold%0d a_ready", i), a_ready_o, 1'b0);
            check($sformatf("hold%0d d_fields", i), {d_opcode_o, d_data_o, d_error_o, d_source_o},
                  {dop, ddata, derr, dsrc});
            @(negedge clk);
        end
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int hold);
        logic [2:0]  dop;
        logic [31:0] ddata;
        logic        derr, got;
        logic [7:0]  dsrc;
        int          lat;
        mem[v.addr[7:2]] = v.init;
        txn(v, hold, dop, ddata, derr, dsrc, lat, got);
        check({tag, " responded"}, got, 1'b1);
        if (got) begin
            check({tag, " d_opcode"}, dop, v.e_op);
            check({tag, " d_data"}, ddata, v.e_data);
            check({tag, " d_error"}, derr, v.e_err);
            check({tag, " d_source"}, dsrc, v.src);
            check({tag, " mem word"}, mem[v.addr[7:2]], v.e_mem);
            check({tag, " mem used"}, req_cycles != 0, !v.e_err);
            check({tag, " addr aligned"}, misaligned, 0);
            check({tag, " wdata stable"}, wdata_moved, 0);
            if (v.e_lat != 0) check({tag, " latency"}, lat, v.e_lat);
            check({tag, " back to idle"}, a_ready_o, 1'b1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t        bp;
        logic [2:0]  dop;
        logic [31:0] ddata;
        logic        derr, got;
        logic [7:0]  dsrc;
        int          lat;
        logic        saw_d, saw_req;

        rst = 1'b1; a_valid = 1'b0; d_ready = 1'b0;
        a_opcode = '0; a_param = '0; a_address = '0; a_data = '0; a_mask = '0; a_source = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst d_valid", d_valid_o, 1'b0);
        check("rst mem_req", mem_req_o, 1'b0);
        check("rst mem_we", mem_we_o, 1'b0);
        check("rst d_error", d_error_o, 1'b0);
        check("rst outputs zero", {d_opcode_o, d_data_o, d_source_o, mem_addr_o, mem_wdata_o, mem_be_o}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst a_ready", a_ready_o, 1'b1);

        // op prm addr data mask src init gl rl | e_op e_data e_err e_mem e_lat
        vecs.push_back(mk(3'd2, 3'd4, 32'h10, 32'h2, 4'h0, 8'h05, 32'hFFFF_FFFF, 0, 1, 3'd1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 4)); // ADD wraps
        vecs.push_back(mk(3'd2, 3'd0, 32'h20, 32'h1, 4'h0, 8'h11, 32'h8000_0000, 0, 1, 3'd1, 32'h8000_0000, 1'b0, 32'h8000_0000, 4)); // MIN signed
        vecs.push_back(mk(3'd2, 3'd2, 32'h20, 32'h1, 4'h0, 8'h12, 32'h8000_0000, 1, 2, 3'd1, 32'h8000_0000, 1'b0, 32'h0000_0001, 0)); // MINU
        vecs.push_back(mk(3'd2, 3'd1, 32'h27, 32'h7, 4'h0, 8'h13, 32'hFFFF_FFFE, 0, 1, 3'd1, 32'hFFFF_FFFE, 1'b0, 32'h0000_0007, 4)); // MAX signed, unaligned addr
        vecs.push_back(mk(3'd2, 3'd3, 32'h24, 32'h7, 4'h0, 8'h14, 32'hFFFF_FFFE, 2, 3, 3'd1, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE, 0)); // MAXU
        vecs.push_back(mk(3'd1, 3'd0, 32'h30, 32'hAABB_CCDD, 4'h3, 8'h21, 32'h1122_3344, 0, 1, 3'd0, 32'h0, 1'b0, 32'h1122_CCDD, 2)); // PutPartial
        vecs.push_back(mk(3'd0, 3'd0, 32'h37, 32'hDEAD_BEEF, 4'h0, 8'h22, 32'h0, 2, 1, 3'd0, 32'h0, 1'b0, 32'hDEAD_BEEF, 0));         // PutFull ignores mask
        vecs.push_back(mk(3'd4, 3'd0, 32'h34, 32'h0, 4'h0, 8'h23, 32'h1234_5678, 1, 3, 3'd1, 32'h1234_5678, 1'b0, 32'h1234_5678, 0)); // Get slow mem
        vecs.push_back(mk(3'd4, 3'd0, 32'h3C, 32'h0, 4'h0, 8'h24, 32'h0BAD_F00D, 0, 1, 3'd1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 3)); // Get fast mem
        vecs.push_back(mk(3'd2, 3'd5, 32'h40, 32'h1, 4'h0, 8'h31, 32'h5555_5555, 0, 1, 3'd1, 32'h0, 1'b1, 32'h5555_5555, 1));         // arith param 5
        vecs.push_back(mk(3'd6, 3'd0, 32'h44, 32'h1, 4'h0, 8'h32, 32'h5555_5555, 0, 1, 3'd1, 32'h0, 1'b1, 32'h5555_5555, 1));         // opcode 6
`ifdef TLUH_LOGICAL_EN
        vecs.push_back(mk(3'd3, 3'd3, 32'h48, 32'h5A, 4'h0, 8'h41, 32'hCAFE_F00D, 0, 1, 3'd1, 32'hCAFE_F00D, 1'b0, 32'h0000_005A, 4)); // SWAP
        vecs.push_back(mk(3'd3, 3'd0, 32'h4C, 32'h0F0F_0F0F, 4'h0, 8'h42, 32'hFF00_FF00, 0, 1, 3'd1, 32'hFF00_FF00, 1'b0, 32'hF00F_F00F, 4)); // XOR
        vecs.push_back(mk(3'd3, 3'd1, 32'h4C, 32'h0F0F_0F0F, 4'h0, 8'h43, 32'hFF00_FF00, 0, 1, 3'd1, 32'hFF00_FF00, 1'b0, 32'hFF0F_FF0F, 4)); // OR
        vecs.push_back(mk(3'd3, 3'd2, 32'h4C, 32'h0F0F_0F0F, 4'h0, 8'h44, 32'hFF00_FF00, 0, 1, 3'd1, 32'hFF00_FF00, 1'b0, 32'h0F00_0F00, 4)); // AND
        vecs.push_back(mk(3'd3, 3'd4, 32'h50, 32'h1, 4'h0, 8'h45, 32'h5555_5555, 0, 1, 3'd1, 32'h0, 1'b1, 32'h5555_5555, 1));           // logical param 4
`else
        vecs.push_back(mk(3'd3, 3'd3, 32'h48, 32'h5A, 4'h0, 8'h41, 32'hCAFE_F00D, 0, 1, 3'd1, 32'h0, 1'b1, 32'hCAFE_F00D, 1));         // SWAP denied
        vecs.push_back(mk(3'd3, 3'd0, 32'h4C, 32'h0F0F_0F0F, 4'h0, 8'h42, 32'hFF00_FF00, 0, 1, 3'd1, 32'h0, 1'b1, 32'hFF00_FF00, 1)); // XOR denied
`endif

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i), 0);

        // D backpressure: d_ready held low for 5 cycles in RESP
        bp = mk(3'd2, 3'd4, 32'h54, 32'h10, 4'h0, 8'h66, 32'h0000_0020, 0, 1, 3'd1, 32'h0000_0020, 1'b0, 32'h0000_0030, 4);
        run_vec(bp, "backpressure", 5);

        // Reset while the read is outstanding (RD_WAIT)
        mem[6'h10] = 32'h0000_0010;
        gnt_lat = 0;
        rd_lat  = 4;
        @(negedge clk);
        a_valid = 1'b1; a_opcode = 3'd2; a_param = 3'd4; a_address = 32'h40;
        a_data = 32'h1; a_mask = 4'h0; a_source = 8'h77;
        check("midrst accept ready", a_ready_o, 1'b1);
        @(posedge clk);
        @(negedge clk);                // RD_REQ, granted on next edge
        a_valid = 1'b0;
        @(negedge clk);                // RD_WAIT
        check("midrst in RD_WAIT", mem_req_o, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst d_valid", d_valid_o, 1'b0);
        check("midrst mem_req", mem_req_o, 1'b0);
        check("midrst mem_we", mem_we_o, 1'b0);
        check("midrst outputs zero", {d_error_o, d_data_o, d_source_o, mem_addr_o, mem_wdata_o, mem_be_o}, '0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst a_ready after release", a_ready_o, 1'b1);
        saw_d = 1'b0; saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_valid_o) saw_d = 1'b1;
            if (mem_req_o) saw_req = 1'b1;
        end
        check("midrst no D response", saw_d, 1'b0);
        check("midrst no mem retry", saw_req, 1'b0);
        check("midrst mem untouched", mem[6'h10], 32'h0000_0010);
        check("midrst idle after stray rvalid", a_ready_o, 1'b1);
        run_vec(mk(3'd2, 3'd4, 32'h40, 32'h1, 4'h0, 8'h78, 32'h0000_0010, 0, 1, 3'd1, 32'h0000_0010, 1'b0, 32'h0000_0011, 4),
                "after midrst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
